// File: rtl/ase_umsg_engine.sv
// ---------------------------------------------------------------------------
// ase_umsg_engine
//
// UMsg delivery engine for the ASE CCI-P emulator. Mailbox writes land in one
// of NUM_UMSG slots. A slot whose contents changed since its last delivery
// optionally emits a hint message and then, after DATA_DELAY cycles, a data
// message carrying its current contents. A round-robin arbiter serialises all
// slot messages onto one registered valid/ready output in RxHdr format.
//
// Ports
//   clk            in   1           single clock
//   rst            in   1           synchronous active-high reset
//   umsg_wr_valid  in   1           mailbox write strobe
//   umsg_wr_id     in   ID_W        target slot (ids >= NUM_UMSG are ignored)
//   umsg_wr_data   in   DATA_WIDTH  new slot contents
//   umsg_hint_en   in   NUM_UMSG    per-slot hint enable, sampled on leaving IDLE
//   rx_ready       in   1           downstream accepts the output this cycle
//   rx_valid       out  1           output message valid
//   rx_hdr         out  28          RxHdr_t (resptype=4'hF, mdata[12]=hint, mdata[ID_W-1:0]=slot)
//   rx_data        out  DATA_WIDTH  payload for data messages, zero for hints
//   umsg_pending   out  NUM_UMSG    bit k set while slot k is not IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ase_umsg_engine #(
    parameter int NUM_UMSG   = 32,
    parameter int DATA_WIDTH = 512,
    parameter int HINT_DELAY = 4,
    parameter int DATA_DELAY = 8,
    parameter int ID_W       = $clog2(NUM_UMSG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  umsg_wr_valid,
    input  logic [ID_W-1:0]       umsg_wr_id,
    input  logic [DATA_WIDTH-1:0] umsg_wr_data,
    input  logic [NUM_UMSG-1:0]   umsg_hint_en,
    input  logic                  rx_ready,
    output logic                  rx_valid,
    output logic [27:0]           rx_hdr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [NUM_UMSG-1:0]   umsg_pending
);

    // Timers count down from (delay-1) to 0, so they never need to wrap.
    localparam int MAX_DELAY = (HINT_DELAY > DATA_DELAY) ? HINT_DELAY : DATA_DELAY;
    localparam int TMR_W     = $clog2(MAX_DELAY + 1);

    localparam logic [TMR_W-1:0] HINT_LOAD = TMR_W'(HINT_DELAY - 1);
    localparam logic [TMR_W-1:0] DATA_LOAD = TMR_W'(DATA_DELAY - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = '0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHANGE    = 3'd1;
    localparam logic [2:0] ST_SEND_HINT = 3'd2;
    localparam logic [2:0] ST_WAITING   = 3'd3;
    localparam logic [2:0] ST_SEND_DATA = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]            state_q     [NUM_UMSG];
    logic [2:0]            state_d     [NUM_UMSG];
    logic [TMR_W-1:0]      timer_q     [NUM_UMSG];
    logic [TMR_W-1:0]      timer_d     [NUM_UMSG];
    logic [DATA_WIDTH-1:0] slot_data_q [NUM_UMSG];   // latest mailbox contents
    logic [DATA_WIDTH-1:0] slot_data_d [NUM_UMSG];
    logic [DATA_WIDTH-1:0] sent_data_q [NUM_UMSG];   // contents last delivered
    logic [DATA_WIDTH-1:0] sent_data_d [NUM_UMSG];
    logic [NUM_UMSG-1:0]   hint_q, hint_d;           // hint enable latched on leaving IDLE
    logic [NUM_UMSG-1:0]   pend_q, pend_d;           // slot not IDLE

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  rx_valid_q, rx_valid_d;
    logic [27:0]           rx_hdr_q, rx_hdr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr_id_ok;
    logic wr_ok;

    // When NUM_UMSG fills the id space every id is legal; otherwise the
    // upper ids address nothing and are dropped.
    generate
        if (NUM_UMSG == (1 << ID_W)) begin : g_full_id
            assign wr_id_ok = 1'b1;
        end else begin : g_part_id
            assign wr_id_ok = (int'(umsg_wr_id) < NUM_UMSG);
        end
    endgenerate

    assign wr_ok = umsg_wr_valid && wr_id_ok;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [NUM_UMSG-1:0] req;
    logic [NUM_UMSG-1:0] gnt_vec;
    logic                gnt_found;
    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_is_hint;
    logic                load;

    // The output register can take a new message when it is empty or the
    // current one is being accepted this cycle.
    assign load = !rx_valid_q || rx_ready;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        req = '0;
        for (int k = 0; k < NUM_UMSG; k++) begin
            req[k] = (state_q[k] == ST_SEND_HINT) || (state_q[k] == ST_SEND_DATA);
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        // Search upward from the pointer, wrapping once around all slots.
        for (int i = 0; i < NUM_UMSG; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_UMSG) begin
                idx = idx - NUM_UMSG;
            end
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    assign gnt_vld     = load && gnt_found;
    assign gnt_is_hint = (state_q[gnt_idx] == ST_SEND_HINT);

    always_comb begin
        gnt_vec = '0;
        if (gnt_vld) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (int'(gnt_idx) == NUM_UMSG - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot state machines
    // ------------------------------------------------------------------
    always_comb begin
        logic wr_hit;
        wr_hit      = 1'b0;
        state_d     = state_q;
        timer_d     = timer_q;
        slot_data_d = slot_data_q;
        sent_data_d = sent_data_q;
        hint_d      = hint_q;
        pend_d      = '0;

        for (int k = 0; k < NUM_UMSG; k++) begin
            wr_hit = wr_ok && (umsg_wr_id == ID_W'(k));

            // Latest write always wins, whatever the slot is doing.
            if (wr_hit) begin
                slot_data_d[k] = umsg_wr_data;
            end

            case (state_q[k])
                ST_IDLE: begin
                    // A write that repeats the last delivered value is absorbed.
                    if (wr_hit && (umsg_wr_data != sent_data_q[k])) begin
                        state_d[k] = ST_CHANGE;
                        hint_d[k]  = umsg_hint_en[k];
                        timer_d[k] = umsg_hint_en[k] ? HINT_LOAD : TMR_ZERO;
                    end
                end

                ST_CHANGE: begin
                    if (timer_q[k] == TMR_ZERO) begin
                        if (hint_q[k]) begin
                            state_d[k] = ST_SEND_HINT;
                        end else begin
                            state_d[k] = ST_WAITING;
                            timer_d[k] = DATA_LOAD;
                        end
                    end else begin
                        timer_d[k] = timer_q[k] - 1'b1;
                    end
                end

                ST_SEND_HINT: begin
                    if (gnt_vec[k]) begin
                        state_d[k] = ST_WAITING;
                        timer_d[k] = DATA_LOAD;
                    end
                end

                ST_WAITING: begin
                    if (timer_q[k] == TMR_ZERO) begin
                        state_d[k] = ST_SEND_DATA;
                    end else begin
                        timer_d[k] = timer_q[k] - 1'b1;
                    end
                end

                ST_SEND_DATA: begin
                    if (gnt_vec[k]) begin
                        // The payload leaving now is the pre-write value; a
                        // write landing on the same edge re-arms the slot if
                        // it differs from what was just sent.
                        sent_data_d[k] = slot_data_q[k];
                        if (wr_hit && (umsg_wr_data != slot_data_q[k])) begin
                            state_d[k] = ST_CHANGE;
                            hint_d[k]  = umsg_hint_en[k];
                            timer_d[k] = umsg_hint_en[k] ? HINT_LOAD : TMR_ZERO;
                        end else begin
                            state_d[k] = ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d[k] = ST_IDLE;
                    timer_d[k] = TMR_ZERO;
                end
            endcase

            pend_d[k] = (state_d[k] != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    function automatic logic [27:0] make_hdr(input logic hint, input logic [ID_W-1:0] id);
        logic [15:0] mdata;
        mdata           = '0;
        mdata[12]       = hint;
        mdata[ID_W-1:0] = id;
        // vc, poison, hitmiss, format, rsvd22, clnum, resptype, mdata
        return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'hF, mdata};
    endfunction

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_hdr_d   = rx_hdr_q;
        rx_data_d  = rx_data_q;
        if (load) begin
            rx_valid_d = gnt_found;
            if (gnt_found) begin
                rx_hdr_d  = make_hdr(gnt_is_hint, gnt_idx);
                rx_data_d = gnt_is_hint ? '0 : slot_data_q[gnt_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot data arrays are reset too; a stale sent value
            // would otherwise suppress or fake a change after reset.
            for (int k = 0; k < NUM_UMSG; k++) begin
                state_q[k]     <= ST_IDLE;
                timer_q[k]     <= '0;
                slot_data_q[k] <= '0;
                sent_data_q[k] <= '0;
            end
            hint_q     <= '0;
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_hdr_q   <= '0;
            rx_data_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_UMSG; k++) begin
                state_q[k]     <= state_d[k];
                timer_q[k]     <= timer_d[k];
                slot_data_q[k] <= slot_data_d[k];
                sent_data_q[k] <= sent_data_d[k];
            end
            hint_q     <= hint_d;
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            rx_valid_q <= rx_valid_d;
            rx_hdr_q   <= rx_hdr_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_hdr       = rx_hdr_q;
    assign rx_data      = rx_data_q;
    assign umsg_pending = pend_q;

endmodule

// File: doc/ase_umsg_engine.md
Name: ase_umsg_engine

Overview:
- Parametrised UMsg delivery engine for the ASE CCI-P emulator, sitting between the software-side UMsg mailbox writes (DPI) and the Rx0 response path.
- Each of NUM_UMSG slots runs its own Idle/ChangeOccured/SendHint/Waiting/SendData state machine with programmable hint and data delays.
- A round-robin arbiter serialises hint and data messages onto a single registered valid/ready output carrying an RxHdr-format header plus a 512-bit payload.

Parameters:
- NUM_UMSG, 32: number of UMsg slots; 2..64.
- DATA_WIDTH, 512: UMsg payload width (CCIP_DATA_WIDTH).
- HINT_DELAY, 4: cycles spent in CHANGE before SEND_HINT when the hint path is enabled; must be ≥1.
- DATA_DELAY, 8: cycles spent in WAITING before SEND_DATA; must be ≥1.
- ID_W, $clog2(NUM_UMSG): slot index width.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- umsg_wr_valid, in, 1: mailbox write strobe.
- umsg_wr_id, in, ID_W: target slot.
- umsg_wr_data, in, DATA_WIDTH: new slot contents.
- umsg_hint_en, in, NUM_UMSG: per-slot hint enable; sampled when a slot leaves IDLE.
- rx_ready, in, 1: downstream accepts the output this cycle.
- rx_valid, out, 1: output message valid.
- rx_hdr, out, 28: RxHdr_t. vc=0, poison=0, hitmiss=0, format=0, rsvd22=0, clnum=0, resptype=4'hF, mdata[12]=hint flag, mdata[ID_W-1:0]=slot id, all other mdata bits 0.
- rx_data, out, DATA_WIDTH: slot data for data messages; all zero for hints.
- umsg_pending, out, NUM_UMSG: bit k is 1 when slot k is not IDLE.

Behaviour:
- Reset (rst sampled high at a clock edge): all slots IDLE, all timers 0, data/data_q/pend cleared to 0, rx_valid=0, rx_hdr=0, rx_data=0, RR pointer=0, umsg_pending=0. Reset mid-operation discards everything in flight, including any held output.
- Write handling: umsg_wr_valid with umsg_wr_id ≥ NUM_UMSG is ignored. Otherwise slot data ← umsg_wr_data at the edge.
  - In IDLE: if wr_data ≠ data_q (last data sent), go to CHANGE and latch hint_en[id]. If equal, the write is absorbed and no message is produced.
  - In any other state: data is overwritten with no restart (latest wins).
- Slot FSM:
  - CHANGE: if hint latched, stay HINT_DELAY cycles, then SEND_HINT. If not latched, stay 1 cycle, then WAITING.
  - SEND_HINT: request; on grant → WAITING.
  - WAITING: stay DATA_DELAY cycles (timer loaded on entry), then SEND_DATA.
  - SEND_DATA: request; on grant, data_q ← data and the payload sent is the data value at the grant cycle → IDLE.
- Write to a slot in its SEND_DATA grant cycle: the old data is sent. The new data is stored and pend is set. The slot enters CHANGE instead of IDLE if new data ≠ the value just sent.
- Arbiter:
  - load = !rx_valid | rx_ready.
  - When load=1, grant exactly one requesting slot (SEND_HINT or SEND_DATA), searching from the RR pointer upward with wrap.
  - Pointer ← granted+1 mod NUM_UMSG.
  - No grants when load=0; requesting slots hold.
- Output register:
  - On grant, rx_valid ← 1 and hdr/data load at the next edge.
  - If load=1 with no grant, rx_valid ← 0.
  - While rx_valid & !rx_ready, rx_hdr/rx_data are held stable.
- Latency with no contention and rx_ready=1, write sampled at edge E0:
  - Hint enabled: hint valid from E0+HINT_DELAY+1; data valid from E0+HINT_DELAY+DATA_DELAY+2.
  - Hint disabled: data valid from E0+DATA_DELAY+2.
- Throughput: one message per cycle maximum.
- Timers are ID-agnostic and width $clog2(max(HINT_DELAY,DATA_DELAY)+1); they never wrap.

Test Plan:
- Reset, then write slot 3 = 0xA5.., hint_en[3]=1, H=4, D=8, rx_ready=1 → hint (mdata=0x1003, data 0) at E0+5; data (mdata=0x0003, payload 0xA5..) at E0+14; umsg_pending[3] drops the same cycle.
- Rewrite slot 3 with the identical 0xA5.. value while IDLE → no rx_valid for 20 cycles; umsg_pending stays 0.
- Writes to slots 0, 5, 31 in the same cycle window, hint off → three data messages on consecutive cycles in RR order 0, 5, 31. Repeat with the pointer at 6 → order 31, 0, 5.
- rx_ready held 0 for 10 cycles while a message is valid → rx_valid/hdr/data stay constant, no other slot is granted. Releasing rx_ready drains the queued messages one per cycle.
- Write slot 7 = X, then write Y during WAITING → a single data message carrying Y. Write Z in the SEND_DATA grant cycle → Y is sent, slot re-enters CHANGE, and Z is delivered DATA_DELAY+2 cycles later.
- Assert rst while slot 2 is in WAITING and an output is held unaccepted → next cycle rx_valid=0, umsg_pending=0, and no message ever appears.
